bcrypt_expand_ctrl: RTL
=======================

Name: bcrypt_expand_ctrl

Overview:
- Sequences one bcrypt/Blowfish ExpandKey pass over the mirrored S-box/P-array SRAM pair, using the feistel encryption datapath.
- Key phase: XORs 18 key words into P[0..17] by read-modify-write.
- Encryption phase: runs 521 chained encryptions and writes each (L,R) result back over P then S.
- Owns both SRAM ports and hands them to the feistel datapath only while an encryption is in flight.

Parameters:
- P_ARRAY_OFFSET, 4000: SRAM word address of P[0]. P[i] is at P_ARRAY_OFFSET+i. S-boxes are at 0..1023.
- N_P, 18: number of P-array words.
- N_S, 1024: number of S-box words.

Ports:
- clk  in  1  clock
- reset_l  in  1  reset, asynchronous, active-low
- start  in  1  begin one ExpandKey pass; sampled only in IDLE
- use_salt  in  1  1: XOR salt into chained L/R before each encryption; 0: plain chaining
- salt  in  128  salt; words s0=[127:96], s1=[95:64], s2=[63:32], s3=[31:0]
- key_idx  out  5  index 0..17 of required key word
- key_word  in  32  key word for key_idx, combinational from external key buffer
- busy  out  1  high from the cycle after an accepted start until DONE
- done  out  1  one-cycle pulse at pass completion
- f_start  out  1  start pulse to feistel
- f_L, f_R  out  32 each  plaintext to feistel
- f_resultL, f_resultR  in  32 each  feistel result
- f_done  in  1  feistel completion pulse
- f_addr_a, f_addr_b  in  12 each  feistel SRAM addresses
- f_cs_a_l, f_we_a_l, f_oe_a_l, f_cs_b_l, f_we_b_l, f_oe_b_l  in  1 each  feistel SRAM controls
- addr_a, addr_b  out  12 each  SRAM addresses
- wdata_a, wdata_b  out  32 each  SRAM write data
- data_a, data_b  in  32 each  SRAM read data; also wired directly to feistel at top level
- cs_a_l, we_a_l, oe_a_l, cs_b_l, we_b_l, oe_b_l  out  1 each  SRAM controls, active-low

Behaviour:
- SRAM model: synchronous read; address/cs in cycle n gives data in cycle n+1. Write occurs in the cycle cs_l=0 and we_l=0.
- Banks A and B are mirrors. Every controller write goes to the same address in both banks.
- Reset (async, any state): state=IDLE, counters=0, chain L/R=0, busy=0, done=0, f_start=0, all cs_l/we_l=1, oe_l=0, addr/wdata=0.
- Port mux: in ENC_WAIT, SRAM outputs are driven from the f_* inputs and wdata=0. In all other states the controller drives them. When idle, cs_l=1 and we_l=1.
- Word counter w: 11 bits, 0..1041. Write address is P_ARRAY_OFFSET+w if w<18, else w-18.
- States and transitions:
  - IDLE: on start, w=0, k=0, L=R=0, go to KEY_RD. start is ignored in every other state.
  - KEY_RD: read P[w] on both ports (cs=0, we=1); key_idx=w. Go to KEY_WR.
  - KEY_WR: write data_a^key_word to P[w] on both ports. If w==17: w=0, go to ENC_START; else w+1, go to KEY_RD.
  - ENC_START: f_start=1 for 1 cycle.
    - f_L = L^(k even ? s0 : s2) if use_salt, else L.
    - f_R = R^(k even ? s1 : s3) if use_salt, else R.
    - Go to ENC_WAIT.
  - ENC_WAIT: f_L/f_R held stable, ports muxed to feistel. On f_done: L=f_resultL, R=f_resultR, go to WR_L.
  - WR_L: write L at addr(w), w+1. Go to WR_R.
  - WR_R: write R at addr(w), w+1, k+1. If the new w==1042 go to DONE, else go to ENC_START.
  - DONE: done=1 for 1 cycle, go to IDLE.
- busy=1 in all states except IDLE and DONE.
- Block counter k: 10 bits, 0..520. Exactly 521 f_start pulses per pass.
- Because feistel reads P during the next encryption, the new P values are visible to the next block (Blowfish semantics).
- f_done outside ENC_WAIT is ignored.
- Latency: 36 cycles key phase, plus 521×(3+feistel latency) cycles, plus 1 cycle for DONE.

Test Plan:
- Reset: drive reset_l low mid-ENC_WAIT → within the same cycle all cs_l=1, busy=0, done=0. After release, start works and the pass completes normally.
- Key phase: SRAM preloaded with P[i]=0x243F6A88+i; key_word=0x11111111×(key_idx+1) → after 36 cycles P[i]=preload^key in both banks, no feistel start yet.
- Full pass: standard Blowfish init tables, 18-word key, use_salt=0, golden feistel model → 521 f_start pulses, final SRAM matches software ExpandKey, done pulses once.
- Salt: use_salt=1, salt=0x0123…CDEF → f_L/f_R of block 0 = s0/s1, block 1 = resultL0^s2 / resultR0^s3, block 2 back to s0/s1.
- Arbitration: during ENC_WAIT, SRAM addr/cs exactly track f_addr/f_cs. Outside ENC_WAIT, toggling f_cs has no effect on SRAM ports.
- Handshake: start asserted while busy or in DONE → ignored, no second pass. A spurious f_done during WR_L → ignored.

Source files
------------

// File: rtl/bcrypt_expand_ctrl.sv
// bcrypt ExpandKey sequencer: XORs the key into P, then runs 521 chained feistel
// encryptions whose results overwrite P and the S-boxes in both mirrored SRAM banks.
module bcrypt_expand_ctrl #(
  parameter int P_ARRAY_OFFSET = 4000,
  parameter int N_P            = 18,
  parameter int N_S            = 1024
) (
  input  logic         clk,
  input  logic         reset_l,
  input  logic         start,
  input  logic         use_salt,
  input  logic [127:0] salt,
  output logic [4:0]   key_idx,
  input  logic [31:0]  key_word,
  output logic         busy,
  output logic         done,
  output logic         f_start,
  output logic [31:0]  f_L,
  output logic [31:0]  f_R,
  input  logic [31:0]  f_resultL,
  input  logic [31:0]  f_resultR,
  input  logic         f_done,
  input  logic [11:0]  f_addr_a,
  input  logic [11:0]  f_addr_b,
  input  logic         f_cs_a_l,
  input  logic         f_we_a_l,
  input  logic         f_oe_a_l,
  input  logic         f_cs_b_l,
  input  logic         f_we_b_l,
  input  logic         f_oe_b_l,
  output logic [11:0]  addr_a,
  output logic [11:0]  addr_b,
  output logic [31:0]  wdata_a,
  output logic [31:0]  wdata_b,
  input  logic [31:0]  data_a,
  input  logic [31:0]  data_b,
  output logic         cs_a_l,
  output logic         we_a_l,
  output logic         oe_a_l,
  output logic         cs_b_l,
  output logic         we_b_l,
  output logic         oe_b_l
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_KEY_RD    = 3'd1;
  localparam logic [2:0] S_KEY_WR    = 3'd2;
  localparam logic [2:0] S_ENC_START = 3'd3;
  localparam logic [2:0] S_ENC_WAIT  = 3'd4;
  localparam logic [2:0] S_WR_L      = 3'd5;
  localparam logic [2:0] S_WR_R      = 3'd6;
  localparam logic [2:0] S_DONE      = 3'd7;

  localparam logic [10:0] W_KEY_LAST = 11'(N_P - 1);
  localparam logic [10:0] W_NP       = 11'(N_P);
  localparam logic [10:0] W_END      = 11'(N_P + N_S);
  localparam logic [11:0] P_BASE     = 12'(P_ARRAY_OFFSET);

  logic [2:0]  r_state;
  logic [10:0] r_w;
  logic [9:0]  r_k;
  logic [31:0] r_L;
  logic [31:0] r_R;

  logic [10:0] w_w_next;
  logic [11:0] w_waddr;
  logic [31:0] w_salt_l;
  logic [31:0] w_salt_r;

  assign w_w_next = r_w + 11'd1;
  // First N_P words of the output stream land in P, the rest fill the S-boxes from 0.
  assign w_waddr  = (r_w < W_NP) ? (P_BASE + {1'b0, r_w}) : {1'b0, r_w - W_NP};

  // Even blocks mix in s0/s1, odd blocks s2/s3.
  assign w_salt_l = r_k[0] ? salt[63:32] : salt[127:96];
  assign w_salt_r = r_k[0] ? salt[31:0]  : salt[95:64];

  assign f_L     = use_salt ? (r_L ^ w_salt_l) : r_L;
  assign f_R     = use_salt ? (r_R ^ w_salt_r) : r_R;
  assign key_idx = r_w[4:0];
  assign f_start = (r_state == S_ENC_START);
  assign done    = (r_state == S_DONE);
  assign busy    = (r_state != S_IDLE) && (r_state != S_DONE);

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      r_state <= S_IDLE;
      r_w     <= '0;
      r_k     <= '0;
      r_L     <= '0;
      r_R     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_w     <= '0;
            r_k     <= '0;
            r_L     <= '0;
            r_R     <= '0;
            r_state <= S_KEY_RD;
          end
        end
        S_KEY_RD: r_state <= S_KEY_WR;
        S_KEY_WR: begin
          if (r_w == W_KEY_LAST) begin
            r_w     <= '0;
            r_state <= S_ENC_START;
          end else begin
            r_w     <= w_w_next;
            r_state <= S_KEY_RD;
          end
        end
        S_ENC_START: r_state <= S_ENC_WAIT;
        S_ENC_WAIT: begin
          if (f_done) begin
            r_L     <= f_resultL;
            r_R     <= f_resultR;
            r_state <= S_WR_L;
          end
        end
        S_WR_L: begin
          r_w     <= w_w_next;
          r_state <= S_WR_R;
        end
        S_WR_R: begin
          r_w     <= w_w_next;
          r_k     <= r_k + 10'd1;
          r_state <= (w_w_next == W_END) ? S_DONE : S_ENC_START;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // SRAM port ownership: feistel only while an encryption is in flight.
  always_comb begin
    addr_a  = '0;
    addr_b  = '0;
    wdata_a = '0;
    wdata_b = '0;
    cs_a_l  = 1'b1;
    we_a_l  = 1'b1;
    oe_a_l  = 1'b0;
    cs_b_l  = 1'b1;
    we_b_l  = 1'b1;
    oe_b_l  = 1'b0;
    case (r_state)
      S_KEY_RD: begin
        addr_a = w_waddr;
        addr_b = w_waddr;
        cs_a_l = 1'b0;
        cs_b_l = 1'b0;
      end
      S_KEY_WR: begin
        addr_a  = w_waddr;
        addr_b  = w_waddr;
        cs_a_l  = 1'b0;
        cs_b_l  = 1'b0;
        we_a_l  = 1'b0;
        we_b_l  = 1'b0;
        wdata_a = data_a ^ key_word;
        wdata_b = data_b ^ key_word;
      end
      S_ENC_WAIT: begin
        addr_a = f_addr_a;
        addr_b = f_addr_b;
        cs_a_l = f_cs_a_l;
        we_a_l = f_we_a_l;
        oe_a_l = f_oe_a_l;
        cs_b_l = f_cs_b_l;
        we_b_l = f_we_b_l;
        oe_b_l = f_oe_b_l;
      end
      S_WR_L, S_WR_R: begin
        addr_a  = w_waddr;
        addr_b  = w_waddr;
        cs_a_l  = 1'b0;
        cs_b_l  = 1'b0;
        we_a_l  = 1'b0;
        we_b_l  = 1'b0;
        wdata_a = (r_state == S_WR_L) ? r_L : r_R;
        wdata_b = (r_state == S_WR_L) ? r_L : r_R;
      end
      default: ;
    endcase
  end

endmodule
